// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - Round-robin sharing of a single-port GPR file with a post-reset zero sweep.
module regfile_arbiter #(
    parameter int NREQ = 3,
    parameter int RW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*RW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [RW-1:0]        rsp_rdata,
    output logic                 init_done,
    output logic                 rf_wen,
    output logic [AW-1:0]        rf_waddr,
    output logic [RW-1:0]        rf_wdata,
    output logic [AW-1:0]        rf_raddr,
    input  logic [RW-1:0]        rf_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic              gnt_found;
    logic [PW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt_oh;
    logic [AW-1:0]     gnt_addr;
    logic [RW-1:0]     gnt_wdata;
    logic              gnt_wen;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    assign gnt_oh    = gnt_found ? (NREQ'(1) << gnt_idx) : '0;
    assign gnt_addr  = req_addr[gnt_idx*AW +: AW];
    assign gnt_wdata = req_wdata[gnt_idx*RW +: RW];
    assign gnt_wen   = req_wen[gnt_idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rsp_valid_d = '0;
        req_ready   = '0;
        rf_wen      = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        rf_raddr    = '0;
        case (state_q)
            ST_INIT: begin
                rf_wen   = 1'b1;
                rf_waddr = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (gnt_found) begin
                    req_ready = gnt_oh;
                    ptr_d     = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                    // Writes to x0 are accepted but never reach the array.
                    if (gnt_wen) begin
                        if (gnt_addr != '0) begin
                            rf_wen   = 1'b1;
                            rf_waddr = gnt_addr;
                            rf_wdata = gnt_wdata;
                        end
                    end else begin
                        rf_raddr    = gnt_addr;
                        rsp_valid_d = gnt_oh;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rf_rdata;
    assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - Scoreboard bench for regfile_arbiter with a behavioural register file.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_wen;
    logic [14:0] req_addr;
    logic [95:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata = '0;

    regfile_arbiter #(.NREQ(3), .RW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (rf_wen) mem[rf_waddr] <= rf_wdata;
        else        rf_rdata <= mem[rf_raddr];
    end

    typedef struct packed {
        int          cyc;
        logic [2:0]  oh;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    logic [31:0] ref_regs [32];
    int          ptr_m = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          started = 0;
    bit          prev_idle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
                sb_e = sb_q.pop_front();
                check_eq("rsp_valid", 64'(rsp_valid), 64'(sb_e.oh));
                check_eq("rsp_rdata", 64'(rsp_rdata), 64'(sb_e.data));
            end else if (rsp_valid !== 3'b000) begin
                check_eq("rsp_spurious", 64'(rsp_valid), 64'(0));
            end
        end
    end

    // Starts #1 after an edge with the DUT in INIT, cnt=0.
    task automatic init_sweep();
        req_valid = 3'b111;
        req_wen   = 3'b000;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_eq("init_wen", 64'(rf_wen), 64'(1));
            check_eq("init_waddr", 64'(rf_waddr), 64'(i));
            check_eq("init_wdata", 64'(rf_wdata), 64'(0));
            check_eq("init_ready", 64'(req_ready), 64'(0));
            check_eq("init_done_low", 64'(init_done), 64'(0));
            check_eq("init_rsp", 64'(rsp_valid), 64'(0));
            @(posedge clk); #1;
        end
        req_valid = 3'b000;
        @(negedge clk);
        check_eq("init_done_high", 64'(init_done), 64'(1));
        check_eq("run_idle_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        ptr_m     = 0;
        prev_idle = 0;
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] w,
                         input logic [14:0] a, input logic [95:0] d);
        int          g;
        logic [4:0]  ag;
        logic [31:0] dg;
        logic [2:0]  oh;
        req_valid = v;
        req_wen   = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        if (prev_idle) check_eq("idle_rsp", 64'(rsp_valid), 64'(0));
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (ptr_m + k) % 3;
            if (g < 0 && v[idx]) g = idx;
        end
        if (g >= 0) begin
            oh = 3'b001 << g;
            ag = a[g*5 +: 5];
            dg = d[g*32 +: 32];
            check_eq("grant", 64'(req_ready), 64'(oh));
            ptr_m = (g + 1) % 3;
            if (w[g]) begin
                check_eq("wr_wen", 64'(rf_wen), 64'(ag != 5'd0));
                if (ag != 5'd0) begin
                    check_eq("wr_waddr", 64'(rf_waddr), 64'(ag));
                    check_eq("wr_wdata", 64'(rf_wdata), 64'(dg));
                    ref_regs[ag] = dg;
                end
            end else begin
                check_eq("rd_wen", 64'(rf_wen), 64'(0));
                check_eq("rd_raddr", 64'(rf_raddr), 64'(ag));
                sb_e.cyc  = cyc + 1;
                sb_e.oh   = oh;
                sb_e.data = ref_regs[ag];
                sb_q.push_back(sb_e);
            end
            prev_idle = 0;
        end else begin
            check_eq("idle_ready", 64'(req_ready), 64'(0));
            check_eq("idle_wen", 64'(rf_wen), 64'(0));
            check_eq("idle_raddr", 64'(rf_raddr), 64'(0));
            prev_idle = 1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        rst       = 1'b1;
        req_valid = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        started   = 1;
        req_valid = 3'b111;
        @(negedge clk);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_init_done", 64'(init_done), 64'(0));
        check_eq("rst_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        init_sweep();

        // All three read continuously: grants 0,1,2,0,1,2 and zeros from the sweep.
        for (int n = 0; n < 6; n++)
            drive(3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, '0);
        drive(3'b000, 3'b000, '0, '0);

        // Requester 1 writes x5, then reads it back.
        drive(3'b010, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0});
        drive(3'b010, 3'b000, {5'd0, 5'd5, 5'd0}, '0);
        drive(3'b000, 3'b000, '0, '0);

        // x0 write is acked but dropped.
        drive(3'b001, 3'b001, '0, {64'h0, 32'h1234_5678});
        drive(3'b001, 3'b000, '0, '0);
        drive(3'b000, 3'b000, '0, '0);

        // Grant to 0, then only requester 2: wrap skip, then idle cycles.
        drive(3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, '0);
        drive(3'b100, 3'b000, {5'd5, 5'd0, 5'd0}, '0);
        drive(3'b000, 3'b000, '0, '0);
        drive(3'b000, 3'b000, '0, '0);

        // Mixed random writes and reads across requesters.
        for (int n = 0; n < 12; n++) begin
            logic [2:0]  rv;
            logic [2:0]  rw;
            logic [14:0] ra;
            logic [95:0] rd;
            rv = 3'($urandom_range(1, 7));
            rw = 3'($urandom);
            ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rd = {$urandom, $urandom, $urandom};
            drive(rv, rw, ra, rd);
        end
        drive(3'b000, 3'b000, '0, '0);

        // Reset arrives in the same cycle as a read grant: response is discarded.
        req_valid = 3'b001;
        req_wen   = 3'b000;
        req_addr  = {10'd0, 5'd5};
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        init_sweep();
        drive(3'b001, 3'b000, {10'd0, 5'd5}, '0);
        drive(3'b000, 3'b000, '0, '0);
        drive(3'b000, 3'b000, '0, '0);

        check_eq("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Sequences the single-port 32x32 GPR file (one access per cycle: write when rf_wen=1, otherwise registered read of rf_raddr) and shares it among NREQ requesters (e.g. EXU writeback, LSU writeback, debug port).
- After reset, runs an init sweep that zeroes all 32 registers. It then arbitrates read/write requests round-robin and routes each registered read result back to its requester.

Parameters:
- NREQ, 3, number of requesters (2..8).
- RW, 32, register data width.
- AW, 5, register address width (32 entries).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; the transfer occurs when req_valid[i]&req_ready[i].
- req_wen  in  NREQ  1=write, 0=read, per requester.
- req_addr  in  NREQ*AW  packed register address; requester i occupies bits [i*AW +: AW].
- req_wdata  in  NREQ*RW  packed write data; requester i occupies bits [i*RW +: RW].
- rsp_valid  out  NREQ  one-hot read response valid.
- rsp_rdata  out  RW  read data, meaningful only while rsp_valid!=0.
- init_done  out  1  high once the zero sweep is complete.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  AW  register file write address.
- rf_wdata  out  RW  register file write data.
- rf_raddr  out  AW  register file read address.
- rf_rdata  in  RW  register file registered read data (valid 1 cycle after a non-write cycle).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - state=INIT, init counter=0, RR pointer=0.
  - rsp_valid=0, init_done=0, req_ready=0.
- FSM INIT:
  - Each cycle drives rf_wen=1, rf_waddr=cnt, rf_wdata=0; cnt increments.
  - After the cnt=31 write, go to RUN on the next edge.
  - req_ready=0 throughout, so INIT lasts exactly 32 cycles after rst deasserts.
- FSM RUN:
  - init_done=1.
  - At most one grant per cycle, chosen combinationally: the first i with req_valid[i]=1, scanning from the RR pointer upward with wrap.
  - req_ready[g]=1 only for the chosen g. req_ready may depend on req_valid.
  - On a grant, the pointer becomes (g+1) mod NREQ. With no grant, the pointer holds.
- RUN, granted write:
  - rf_wen=1, rf_waddr=addr_g, rf_wdata=wdata_g.
  - Write to addr 0: acked but dropped (rf_wen=0), x0 stays zero. No response is produced.
- RUN, granted read:
  - rf_wen=0, rf_raddr=addr_g.
  - Next cycle: rsp_valid=onehot(g), rsp_rdata=rf_rdata.
  - Read of addr 0 is issued normally and returns 0 due to the init sweep and dropped x0 writes.
- RUN, idle (no grant): rf_wen=0, rf_raddr=0, rsp_valid=0 the following cycle.
- Latency: write is visible to a read granted in the following cycle (the register file updates at the same edge). Read data is returned 1 cycle after grant, fixed. No backpressure on responses.
- Back-to-back reads from the same requester on consecutive cycles produce consecutive rsp_valid pulses.
- Outputs not listed above: rf_waddr and rf_wdata are don't-care when rf_wen=0, but are driven deterministically (0) for lint/trace cleanliness.
- rst asserted mid-operation:
  - Next edge returns to INIT with cnt=0 and rsp_valid=0.
  - Any pending read response is discarded.
  - The zero sweep reruns fully.
- Requester holding req_valid without ready: must keep the request stable (standard valid/ready). The arbiter guarantees service within NREQ grant cycles.

Test Plan:
- Reset -> rf_wen=1 for exactly 32 cycles with rf_waddr 0..31, rf_wdata=0, req_ready=0; init_done rises on cycle 33.
- After init, requester 1 writes x5=0xDEADBEEF, then reads x5 the next cycle -> rsp_valid=3'b010 one cycle after the read grant, rsp_rdata=0xDEADBEEF.
- All 3 requesters hold read requests continuously (NREQ=3) -> grants cycle 0,1,2,0,1,2 (pointer starting at 0); each rsp_valid is one-hot and matches the grant one cycle earlier.
- Requester 0 writes x0=0x12345678, then reads x0 -> rf_wen stays 0 on the write grant; read returns 0x00000000.
- Only requester 2 is active after a grant to 0 -> requester 2 is granted immediately (wrap skip); the idle cycle that follows yields rsp_valid=0.
- Assert rst for one cycle while a read response is pending -> rsp_valid=0 next cycle, INIT restarts at rf_waddr=0, and previously written x5 reads 0 after the sweep.
